tlb_walk_scheduler: RTL and testbench

- Shared Sv32 page-table walker that serves both the iTLB and the dTLB through one memory read port.
- Arbitrates walk requests between the two TLBs (round-robin) and sequences the two-level walk.
- Returns the leaf PTE or a page fault to the requesting TLB.
- Serialises sfence.vma against in-flight walks; sits between the TLBs and the cache/memory arbiter.

---
 rtl/priv_isa_types_pkg.sv | 57 +++++
 rtl/tlb_walk_scheduler_rr_arbiter2.sv | 39 +++
 rtl/tlb_walk_scheduler.sv | 156 +++++++++++++++
 tb/tb_tlb_walk_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/priv_isa_types_pkg.sv
// Shared privileged-ISA types for the Sv32 page-table walker.
//   sv32_pte_t      : Sv32 page-table entry layout
//   ptw_state_t     : walker FSM states
//   ptw_requester_t : walk requesters (iTLB / dTLB)
//   pte_kind_t      : result of classifying a fetched PTE
//   pte_classify()  : PTE classification shared by both walk levels
package priv_isa_types_pkg;

  typedef struct packed {
    logic [11:0] ppn1;
    logic [9:0]  ppn0;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } sv32_pte_t;

  typedef enum logic [2:0] {
    IDLE,
    LVL1,
    LVL0,
    DONE,
    FENCE
  } ptw_state_t;

  typedef enum logic {
    ITLB = 1'b0,
    DTLB = 1'b1
  } ptw_requester_t;

  typedef enum logic [1:0] {
    PTE_INVALID,
    PTE_LEAF,
    PTE_POINTER
  } pte_kind_t;

  // Sv32 PTE physical addresses are 34 bits wide before truncation.
  localparam int unsigned SV32_PTE_ADDR_W = 34;

  // Invalid: V clear or the reserved W-without-R encoding.
  // Leaf: R or X set. Anything else points to the next level.
  function automatic pte_kind_t pte_classify(input sv32_pte_t p);
    if (!p.v || (!p.r && p.w)) begin
      return PTE_INVALID;
    end else if (p.r || p.x) begin
      return PTE_LEAF;
    end else begin
      return PTE_POINTER;
    end
  endfunction

endpackage

// File: rtl/tlb_walk_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter for the shared page-table walker.
//   CLK, nRST : clock, asynchronous active-low reset
//   en        : grant enable; no grant and no pointer update when low
//   req       : request vector indexed by ptw_requester_t
//   gnt_valid : a grant is issued this cycle
//   gnt_id    : requester granted this cycle
// The last-grant register resets to ITLB so the dTLB wins the first tie.
module rr_arbiter2
  import priv_isa_types_pkg::*;
(
  input  logic           CLK,
  input  logic           nRST,
  input  logic           en,
  input  logic [1:0]     req,
  output logic           gnt_valid,
  output ptw_requester_t gnt_id
);

  ptw_requester_t last_q;

  always_comb begin
    gnt_valid = en && (|req);
    gnt_id    = ITLB;
    if (req[DTLB] && req[ITLB]) begin
      gnt_id = (last_q == ITLB) ? DTLB : ITLB;
    end else if (req[DTLB]) begin
      gnt_id = DTLB;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_q <= ITLB;
    end else if (gnt_valid) begin
      last_q <= gnt_id;
    end
  end

endmodule

// File: rtl/tlb_walk_scheduler.sv
// Shared Sv32 page-table walker serving the iTLB and dTLB over one
// memory read port, with sfence.vma serialisation.
//   CLK, nRST            : clock, asynchronous active-low reset
//   satp                 : [31] mode, [21:0] root PPN
//   itlb_req/va/done     : iTLB walk request (level), miss VA, done pulse
//   dtlb_req/va/done     : dTLB walk request (level), miss VA, done pulse
//   walk_pte             : leaf PTE, valid with a done pulse
//   walk_superpage       : leaf found at level 1
//   walk_fault           : walk ended in a page fault
//   fence_req, fence_ack : sfence.vma request (level) / ack pulse
//   mem_ren, mem_addr    : PTE read request and physical address
//   mem_rdata, mem_busy  : PTE data; read completes when ren=1 and busy=0
module tlb_walk_scheduler
  import priv_isa_types_pkg::*;
#(
  parameter int unsigned PADDR_WIDTH = 32,
  parameter int unsigned VA_WIDTH    = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [31:0]            satp,
  input  logic                   itlb_req,
  input  logic [VA_WIDTH-1:0]    itlb_va,
  output logic                   itlb_done,
  input  logic                   dtlb_req,
  input  logic [VA_WIDTH-1:0]    dtlb_va,
  output logic                   dtlb_done,
  output logic [31:0]            walk_pte,
  output logic                   walk_superpage,
  output logic                   walk_fault,
  input  logic                   fence_req,
  output logic                   fence_ack,
  output logic                   mem_ren,
  output logic [PADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]            mem_rdata,
  input  logic                   mem_busy
);

  ptw_state_t     state_q, state_d;
  ptw_requester_t grantee_q, gnt_id;
  logic           gnt_en, gnt_valid;
  logic [19:0]    vpn_q;        // latched va[31:12]
  logic [21:0]    root_ppn_q;   // latched satp PPN
  logic [31:0]    pte_q;
  logic           sp_q, fault_q;
  sv32_pte_t      rd_pte;
  pte_kind_t      rd_kind;
  logic           rd_fire;
  logic [SV32_PTE_ADDR_W-1:0] pte_addr;
  logic           unused_bits;

  // Fence takes priority over new grants, so arbitration is held off
  // whenever a fence is pending in IDLE.
  assign gnt_en = (state_q == IDLE) && !fence_req;

  rr_arbiter2 u_arb (
    .CLK       (CLK),
    .nRST      (nRST),
    .en        (gnt_en),
    .req       ({dtlb_req, itlb_req}),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign rd_pte  = sv32_pte_t'(mem_rdata);
  assign rd_kind = pte_classify(rd_pte);
  assign mem_ren = (state_q == LVL1) || (state_q == LVL0);
  assign rd_fire = mem_ren && !mem_busy;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (fence_req) begin
          state_d = FENCE;
        end else if (gnt_valid) begin
          state_d = satp[31] ? LVL1 : DONE;
        end
      end
      LVL1: begin
        if (!mem_busy) begin
          state_d = (rd_kind == PTE_POINTER) ? LVL0 : DONE;
        end
      end
      LVL0: begin
        if (!mem_busy) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      FENCE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      grantee_q  <= ITLB;
      vpn_q      <= '0;
      root_ppn_q <= '0;
      pte_q      <= '0;
      sp_q       <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      if (gnt_valid) begin
        grantee_q  <= gnt_id;
        vpn_q      <= (gnt_id == DTLB) ? dtlb_va[31:12] : itlb_va[31:12];
        root_ppn_q <= satp[21:0];
        pte_q      <= '0;
        sp_q       <= 1'b0;
        // Bare mode at grant goes straight to DONE as a fault.
        fault_q    <= !satp[31];
      end
      if (rd_fire) begin
        pte_q <= mem_rdata;
        if (state_q == LVL1) begin
          fault_q <= (rd_kind == PTE_INVALID) ||
                     ((rd_kind == PTE_LEAF) && (rd_pte.ppn0 != '0));
          sp_q    <= (rd_kind == PTE_LEAF) && (rd_pte.ppn0 == '0);
        end else begin
          fault_q <= (rd_kind != PTE_LEAF);
          sp_q    <= 1'b0;
        end
      end
    end
  end

  // The level-0 address uses the level-1 PTE still held in pte_q.
  always_comb begin
    pte_addr = '0;
    if (state_q == LVL1) begin
      pte_addr = {root_ppn_q, vpn_q[19:10], 2'b00};
    end else if (state_q == LVL0) begin
      pte_addr = {pte_q[31:10], vpn_q[9:0], 2'b00};
    end
  end

  assign mem_addr       = pte_addr[PADDR_WIDTH-1:0];
  assign itlb_done      = (state_q == DONE) && (grantee_q == ITLB);
  assign dtlb_done      = (state_q == DONE) && (grantee_q == DTLB);
  assign fence_ack      = (state_q == FENCE);
  assign walk_pte       = pte_q;
  assign walk_superpage = sp_q;
  assign walk_fault     = fault_q;

  assign unused_bits = ^{satp[30:22], itlb_va[11:0], dtlb_va[11:0], pte_addr};

endmodule

// File: tb/tb_tlb_walk_scheduler.sv
module tb_tlb_walk_scheduler;

  typedef struct {
    bit          fault;
    bit          sp;
    logic [31:0] pte;
    logic [31:0] a1;
    logic [31:0] a2;
    int unsigned nreads;
    int unsigned lat;
  } exp_t;

  typedef struct {
    bit          who;   // 1 = dTLB
    logic [31:0] s;
    logic [31:0] va;
    logic [31:0] l1;
    logic [31:0] l0;
    int unsigned w;
    exp_t        e;
  } vec_t;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] satp = '0;
  logic        itlb_req = 1'b0, dtlb_req = 1'b0, fence_req = 1'b0;
  logic [31:0] itlb_va = '0, dtlb_va = '0;
  logic        itlb_done, dtlb_done, walk_superpage, walk_fault, fence_ack, mem_ren;
  logic [31:0] walk_pte, mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_busy = 1'b0;

  int unsigned n_vec = 0, n_err = 0;

  tlb_walk_scheduler #(.PADDR_WIDTH(32), .VA_WIDTH(32)) dut (
    .CLK(CLK), .nRST(nRST), .satp(satp),
    .itlb_req(itlb_req), .itlb_va(itlb_va), .itlb_done(itlb_done),
    .dtlb_req(dtlb_req), .dtlb_va(dtlb_va), .dtlb_done(dtlb_done),
    .walk_pte(walk_pte), .walk_superpage(walk_superpage), .walk_fault(walk_fault),
    .fence_req(fence_req), .fence_ack(fence_ack),
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_busy(mem_busy)
  );

  always #5 CLK = ~CLK;

  // Memory responder: serves queued PTE data in read order, inserts
  // wait_cfg busy cycles per read, logs completed read addresses and
  // counts address changes while a read is stalled.
  logic [31:0] rsp_q[$];
  logic [31:0] addr_q[$];
  int unsigned wait_cfg = 0, wait_left = 0, addr_jitter = 0;
  bit          in_read = 1'b0;
  logic [31:0] read_addr = '0;

  always @(negedge CLK) begin
    if (mem_ren) begin
      if (!in_read) begin
        in_read   = 1'b1;
        wait_left = wait_cfg;
        read_addr = mem_addr;
      end else if (mem_addr !== read_addr) begin
        addr_jitter++;
      end
      if (wait_left > 0) begin
        wait_left--;
        mem_busy  = 1'b1;
        mem_rdata = $urandom;
      end else begin
        mem_busy  = 1'b0;
        mem_rdata = (rsp_q.size() > 0) ? rsp_q.pop_front() : 32'h0;
        addr_q.push_back(mem_addr);
        in_read   = 1'b0;
      end
    end else begin
      in_read   = 1'b0;
      mem_busy  = 1'b0;
      mem_rdata = $urandom;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: Sv32 two-level walk from the architectural rules.
  function automatic bit pte_valid(input logic [31:0] p);
    return p[0] && !(p[2] && !p[1]);
  endfunction

  function automatic bit pte_leaf(input logic [31:0] p);
    return p[1] || p[3];
  endfunction

  function automatic exp_t model(input logic [31:0] s, input logic [31:0] va,
                                 input logic [31:0] l1, input logic [31:0] l0,
                                 input int unsigned w);
    exp_t e;
    logic [63:0] a;
    e.fault = 0; e.sp = 0; e.a2 = '0; e.nreads = 1; e.pte = l1;
    a = {32'b0, s & 32'h003F_FFFF} * 64'd4096 + {32'b0, va >> 22} * 64'd4;
    e.a1 = a[31:0];
    if (!pte_valid(l1)) begin
      e.fault = 1;
    end else if (pte_leaf(l1)) begin
      if (((l1 >> 10) & 32'h3FF) != 0) e.fault = 1;
      else e.sp = 1;
    end else begin
      e.nreads = 2;
      a = {32'b0, l1 >> 10} * 64'd4096 + {32'b0, (va >> 12) & 32'h3FF} * 64'd4;
      e.a2 = a[31:0];
      e.pte = l0;
      if (!pte_valid(l0) || !pte_leaf(l0)) e.fault = 1;
    end
    e.lat = 1 + e.nreads * (1 + w);
    return e;
  endfunction

  function automatic logic [31:0] rnd_pte(input int unsigned kind);
    case (kind)
      1:       return ($urandom & 32'hFFFF_FC00) | ($urandom & 32'h0000_03F0) | 32'h1;
      2:       return ($urandom & 32'hFFF0_0000) | ($urandom & 32'h0000_03F0) | 32'h3;
      3:       return ($urandom & 32'hFFFF_FC00) | 32'h0000_0409;
      4:       return ($urandom & 32'hFFFF_FFF0) | 32'h5;
      default: return $urandom;
    endcase
  endfunction

  function automatic exp_t mk_exp(input bit f, input bit sp, input logic [31:0] pte,
                                  input logic [31:0] a1, input logic [31:0] a2,
                                  input int unsigned nr, input int unsigned lat);
    exp_t e;
    e.fault = f; e.sp = sp; e.pte = pte; e.a1 = a1; e.a2 = a2; e.nreads = nr; e.lat = lat;
    return e;
  endfunction

  function automatic vec_t mk_vec(input bit who, input logic [31:0] s, input logic [31:0] va,
                                  input logic [31:0] l1, input logic [31:0] l0,
                                  input int unsigned w, input exp_t e);
    vec_t v;
    v.who = who; v.s = s; v.va = va; v.l1 = l1; v.l0 = l0; v.w = w; v.e = e;
    return v;
  endfunction

  // Starts at cycle 0 (a negedge with the walker idle and req raised);
  // waits for the done pulse, checks it, and returns one cycle later.
  task automatic wait_check(input string tag, input bit who, input exp_t e);
    int unsigned cyc = 0;
    bit seen = 0;
    while (!seen && cyc < 100) begin
      @(negedge CLK);
      cyc++;
      if (itlb_done || dtlb_done) begin
        seen = 1;
        check({tag, " done_sel"}, {30'b0, itlb_done, dtlb_done}, who ? 32'd1 : 32'd2);
        check({tag, " latency"}, cyc, e.lat);
        check({tag, " pte"}, walk_pte, e.pte);
        check({tag, " superpage"}, {31'b0, walk_superpage}, {31'b0, e.sp});
        check({tag, " fault"}, {31'b0, walk_fault}, {31'b0, e.fault});
        check({tag, " nreads"}, addr_q.size(), e.nreads);
        if (e.nreads >= 1 && addr_q.size() >= 1) check({tag, " addr1"}, addr_q[0], e.a1);
        if (e.nreads >= 2 && addr_q.size() >= 2) check({tag, " addr2"}, addr_q[1], e.a2);
        itlb_req = 1'b0;
        dtlb_req = 1'b0;
      end
    end
    check({tag, " timeout"}, {31'b0, seen}, 32'd1);
    @(negedge CLK);
    check({tag, " done_width"}, {31'b0, itlb_done | dtlb_done}, 32'd0);
  endtask

  task automatic do_walk(input string tag, input vec_t v);
    assert (v.s[31]) else $error("walk requested with satp.mode=0");
    addr_q.delete();
    rsp_q.delete();
    rsp_q.push_back(v.l1);
    rsp_q.push_back(v.l0);
    wait_cfg = v.w;
    satp = v.s;
    if (v.who) begin dtlb_va = v.va; dtlb_req = 1'b1; end
    else       begin itlb_va = v.va; itlb_req = 1'b1; end
    wait_check(tag, v.who, v.e);
  endtask

  localparam logic [31:0] S   = 32'h8008_0000;
  localparam logic [31:0] VA  = 32'h0040_1000;
  localparam logic [31:0] A1  = 32'h8000_0004;
  localparam logic [31:0] A2  = 32'h0000_8004;

  vec_t        tbl[11];
  logic [1:0]  order[4];
  int unsigned n_done;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk_vec(1, S, VA, 32'h0000_2001, 32'h0000_300F, 0, mk_exp(0, 0, 32'h0000_300F, A1, A2, 2, 3));
    tbl[1]  = mk_vec(1, S, VA, 32'h2000_000F, 32'h0, 0, mk_exp(0, 1, 32'h2000_000F, A1, 0, 1, 2));
    tbl[2]  = mk_vec(1, S, VA, 32'h2000_040F, 32'h0, 0, mk_exp(1, 0, 32'h2000_040F, A1, 0, 1, 2));
    tbl[3]  = mk_vec(0, S, VA, 32'h0000_0000, 32'h0, 0, mk_exp(1, 0, 32'h0000_0000, A1, 0, 1, 2));
    tbl[4]  = mk_vec(0, S, VA, 32'h0000_0005, 32'h0, 0, mk_exp(1, 0, 32'h0000_0005, A1, 0, 1, 2));
    tbl[5]  = mk_vec(1, S, VA, 32'h0000_2001, 32'h0000_0001, 0, mk_exp(1, 0, 32'h0000_0001, A1, A2, 2, 3));
    tbl[6]  = mk_vec(0, S, VA, 32'h0000_2001, 32'h0000_300F, 2, mk_exp(0, 0, 32'h0000_300F, A1, A2, 2, 7));
    tbl[7]  = mk_vec(1, S, 32'hFFC0_0000, 32'h1000_000B, 32'h0, 0, mk_exp(0, 1, 32'h1000_000B, 32'h8000_0FFC, 0, 1, 2));
    tbl[8]  = mk_vec(0, 32'h803F_FFFF, VA, 32'h0000_0007, 32'h0, 1, mk_exp(0, 1, 32'h0000_0007, 32'hFFFF_F004, 0, 1, 3));
    tbl[9]  = mk_vec(1, S, VA, 32'h0000_2001, 32'h0000_000D, 0, mk_exp(1, 0, 32'h0000_000D, A1, A2, 2, 3));
    tbl[10] = mk_vec(1, S, VA, 32'hFFFF_FC01, 32'h0000_00CB, 0, mk_exp(0, 0, 32'h0000_00CB, A1, 32'hFFFF_F004, 2, 3));

    // Reset state
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst mem_ren", {31'b0, mem_ren}, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst dones", {30'b0, itlb_done, dtlb_done}, 0);
    check("rst fence_ack", {31'b0, fence_ack}, 0);
    check("rst walk_pte", walk_pte, 0);
    check("rst flags", {30'b0, walk_superpage, walk_fault}, 0);
    nRST = 1'b1;

    // Round-robin with both requests held: dTLB wins the first tie
    rsp_q.delete();
    repeat (4) rsp_q.push_back(32'h0000_000F);
    wait_cfg = 0; satp = S; itlb_va = VA; dtlb_va = VA;
    itlb_req = 1'b1; dtlb_req = 1'b1;
    n_done = 0;
    for (int c = 0; c < 60 && n_done < 4; c++) begin
      @(negedge CLK);
      if (itlb_done || dtlb_done) begin
        order[n_done] = {itlb_done, dtlb_done};
        n_done++;
      end
    end
    itlb_req = 1'b0; dtlb_req = 1'b0;
    check("arb grants", n_done, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("arb order%0d", i), {30'b0, order[i]}, (i % 2 == 0) ? 32'd1 : 32'd2);
    @(negedge CLK);

    // Directed vector table
    for (int i = 0; i < 11; i++) do_walk($sformatf("vec%0d", i), tbl[i]);

    // Fence raised mid-walk while mem_busy stalls level 1
    addr_q.delete(); rsp_q.delete(); addr_jitter = 0;
    rsp_q.push_back(32'h0000_000F);
    rsp_q.push_back(32'h0000_000F);
    wait_cfg = 5; satp = S; dtlb_va = VA; dtlb_req = 1'b1;
    begin
      int unsigned done_c = 0, ack_c = 0, ack_n = 0, ren_c = 0, idone_c = 0;
      for (int unsigned c = 1; c <= 40; c++) begin
        @(negedge CLK);
        if (c == 2) begin
          fence_req = 1'b1; itlb_va = 32'h0080_0000; itlb_req = 1'b1; wait_cfg = 0;
        end
        if (dtlb_done) begin done_c = c; dtlb_req = 1'b0; end
        if (fence_ack) begin ack_n++; if (ack_c == 0) ack_c = c; fence_req = 1'b0; end
        if (mem_ren && done_c != 0 && ren_c == 0) ren_c = c;
        if (itlb_done) begin idone_c = c; itlb_req = 1'b0; end
      end
      check("fence addr stable", addr_jitter, 0);
      check("fence done cycle", done_c, 7);
      check("fence ack cycle", ack_c, 9);
      check("fence ack width", ack_n, 1);
      check("fence next grant read", ren_c, 11);
      check("fence itlb done", idone_c, 12);
    end

    // Reset asserted during the level-0 read, then restart of held request
    addr_q.delete(); rsp_q.delete();
    rsp_q.push_back(32'h0000_2001);
    rsp_q.push_back(32'h0000_300F);
    wait_cfg = 3; satp = S; dtlb_va = VA; dtlb_req = 1'b1;
    repeat (5) @(negedge CLK);
    check("midrst pre ren", {31'b0, mem_ren}, 1);
    check("midrst pre addr", mem_addr, A2);
    #2 nRST = 1'b0;
    #1;
    check("midrst ren", {31'b0, mem_ren}, 0);
    check("midrst addr", mem_addr, 0);
    check("midrst dones", {30'b0, itlb_done, dtlb_done}, 0);
    check("midrst pte", walk_pte, 0);
    check("midrst flags", {29'b0, walk_superpage, walk_fault, fence_ack}, 0);
    @(negedge CLK);
    addr_q.delete(); rsp_q.delete();
    rsp_q.push_back(32'h0000_2001);
    rsp_q.push_back(32'h0000_300F);
    wait_cfg = 0;
    @(negedge CLK);
    nRST = 1'b1;
    wait_check("midrst restart", 1'b1, tbl[0].e);

    // Randomized walks against the reference model
    for (int i = 0; i < 60; i++) begin
      vec_t v;
      v.who = $urandom_range(0, 1);
      v.s   = 32'h8000_0000 | ($urandom & 32'h003F_FFFF);
      v.va  = $urandom;
      v.l1  = rnd_pte($urandom_range(0, 4));
      v.l0  = rnd_pte($urandom_range(0, 4));
      v.w   = $urandom_range(0, 2);
      v.e   = model(v.s, v.va, v.l1, v.l0, v.w);
      do_walk($sformatf("rnd%0d", i), v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
